// File: rtl/cnn_out_writer_pkg.sv
// Shared widths, layer constants and FSM encoding for the output writer.
package cnn_out_writer_pkg;

    localparam int IN_W     = 21;
    localparam int ACT_W    = 8;
    localparam int CORE_NUM = 3;
    localparam int WORD_W   = CORE_NUM * ACT_W;
    localparam int LANE_W   = $clog2(CORE_NUM);
    localparam int SHIFT_W  = 5;

    localparam logic [1:0] LAYER_RAW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnn_out_writer_requant_relu.sv
// ReLU, round-half-up right shift and saturation of one core result to an 8-bit activation.
module requant_relu
    import cnn_out_writer_pkg::*;
(
    input  logic [IN_W-1:0]    i_data,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [ACT_W-1:0]   o_act
);

    localparam int SUM_W = IN_W + 1;
    localparam int ACT_MAX = (1 << ACT_W) - 1;

    logic [SUM_W-1:0] relu;
    logic [SUM_W-1:0] rnd;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] q;

    always_comb begin
        relu = i_data[IN_W-1] ? '0 : {1'b0, i_data};
        rnd  = '0;
        if (i_shift != '0)
            rnd = SUM_W'(1) << (i_shift - SHIFT_W'(1));
        // One extra bit of headroom keeps the rounding add from wrapping
        sum  = relu + rnd;
        q    = sum >> i_shift;
        o_act = (q > SUM_W'(ACT_MAX)) ? '1 : q[ACT_W-1:0];
    end

endmodule

// File: rtl/cnn_out_writer.sv
// Requantizes the core result stream, packs CORE_NUM activations per word and writes them to SRAM.
module cnn_out_writer
    import cnn_out_writer_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_layer_num,
    input  logic [SHIFT_W-1:0]  i_shift,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [CNT_W-1:0]    i_num_out,
    input  logic                i_valid,
    input  logic [IN_W-1:0]     i_data,
    output logic                o_busy,
    output logic                o_wen,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [WORD_W-1:0]   o_wdata,
    output logic                o_done
);

    state_t              state_q, state_d;
    logic                raw_q;
    logic [SHIFT_W-1:0]  shift_q;
    logic [CNT_W-1:0]    num_m1_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [LANE_W-1:0]   lane_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   pack_q;

    logic                start_ok;
    logic                zero_job;
    logic                accept;
    logic                last_beat;
    logic                word_done;
    logic [ACT_W-1:0]    act;
    logic [WORD_W-1:0]   word_d;

    requant_relu u_requant (
        .i_data  (i_data),
        .i_shift (shift_q),
        .o_act   (act)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        zero_job  = 1'b0;
        accept    = 1'b0;
        last_beat = cnt_q == num_m1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    start_ok = 1'b1;
                    if (i_num_out == '0) zero_job = 1'b1;
                    else                 state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_valid) begin
                    accept = 1'b1;
                    if (last_beat) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        word_done = accept && (raw_q || last_beat || (lane_q == LANE_W'(CORE_NUM - 1)));

        word_d = pack_q;
        for (int unsigned k = 0; k < CORE_NUM; k++) begin
            if (lane_q == LANE_W'(k))
                word_d[k*ACT_W +: ACT_W] = act;
        end
        if (raw_q)
            word_d = {{(WORD_W-IN_W){i_data[IN_W-1]}}, i_data};
    end

    assign o_busy = (state_q == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q    <= 1'b0;
            shift_q  <= '0;
            num_m1_q <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
            addr_q   <= '0;
            pack_q   <= '0;
            o_wen    <= 1'b0;
            o_addr   <= '0;
            o_wdata  <= '0;
            o_done   <= 1'b0;
        end else begin
            o_wen  <= 1'b0;
            o_done <= 1'b0;
            if (start_ok) begin
                raw_q    <= (i_layer_num == LAYER_RAW);
                shift_q  <= i_shift;
                num_m1_q <= i_num_out - CNT_W'(1);
                cnt_q    <= '0;
                lane_q   <= '0;
                pack_q   <= '0;
                addr_q   <= i_base_addr;
                o_done   <= zero_job;
            end
            if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (word_done) begin
                    o_wen   <= 1'b1;
                    o_addr  <= addr_q;
                    o_wdata <= word_d;
                    addr_q  <= addr_q + ADDR_W'(1);
                    lane_q  <= '0;
                    pack_q  <= '0;
                end else begin
                    lane_q  <= lane_q + LANE_W'(1);
                    pack_q  <= word_d;
                end
                o_done <= last_beat;
            end
        end
    end

endmodule

// File: tb/tb_cnn_out_writer.sv
// Self-checking bench for cnn_out_writer: directed table, corner sequences and randomized jobs.
module tb_cnn_out_writer;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_layer_num;
    logic [4:0]  i_shift;
    logic [11:0] i_base_addr;
    logic [11:0] i_num_out;
    logic        i_valid;
    logic [20:0] i_data;
    logic        o_busy;
    logic        o_wen;
    logic [11:0] o_addr;
    logic [23:0] o_wdata;
    logic        o_done;

    cnn_out_writer #(.ADDR_W(12), .CNT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_layer_num(i_layer_num),
        .i_shift(i_shift), .i_base_addr(i_base_addr), .i_num_out(i_num_out),
        .i_valid(i_valid), .i_data(i_data), .o_busy(o_busy), .o_wen(o_wen),
        .o_addr(o_addr), .o_wdata(o_wdata), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic        done;
        logic        busy;
        logic [11:0] addr;
        logic [23:0] data;
    } rec_t;

    typedef struct packed {
        logic [1:0]        layer;
        logic [4:0]        shift;
        logic [3:0]        num;
        logic [11:0]       base;
        logic [3:0]        gap_after;
        logic [3:0][20:0]  beats;
        logic [1:0]        nexp;
        logic [1:0][11:0]  eaddr;
        logic [1:0][23:0]  edata;
    } vec_t;

    rec_t        rec_q[$];
    rec_t        exp_q[$];
    logic [20:0] beat_q[$];
    int          gap_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk) begin
        #1;
        if (o_wen || o_done)
            rec_q.push_back('{wen: o_wen, done: o_done, busy: o_busy, addr: o_addr, data: o_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int layer, input int shift, input int num, input int base,
                                input int gap, input int b0, input int b1, input int b2, input int b3,
                                input int nexp, input int a0, input int d0, input int a1, input int d1);
        vec_t v;
        v.layer = 2'(layer);  v.shift = 5'(shift);  v.num = 4'(num);
        v.base = 12'(base);   v.gap_after = 4'(gap);
        v.beats[0] = 21'(b0); v.beats[1] = 21'(b1); v.beats[2] = 21'(b2); v.beats[3] = 21'(b3);
        v.nexp = 2'(nexp);
        v.eaddr[0] = 12'(a0); v.edata[0] = 24'(d0);
        v.eaddr[1] = 12'(a1); v.edata[1] = 24'(d1);
        return v;
    endfunction

    // Reference: activations from plain integer arithmetic, then grouped into 3-byte words
    task automatic model(input int layer, input int shift, input int base);
        int     n;
        int     acts[$];
        longint v, q;
        int     nw;
        exp_q.delete();
        n = beat_q.size();
        if (n == 0) begin
            exp_q.push_back('{wen: 1'b0, done: 1'b1, busy: 1'b0, addr: 12'd0, data: 24'd0});
            return;
        end
        for (int k = 0; k < n; k++) begin
            v = longint'($signed(beat_q[k]));
            if (layer == 2) begin
                acts.push_back(int'(v));
            end else begin
                if (v < 0) v = 0;
                q = (shift == 0) ? v : (v + (longint'(1) << (shift - 1))) / (longint'(1) << shift);
                acts.push_back(q > 255 ? 255 : int'(q));
            end
        end
        if (layer == 2) begin
            for (int k = 0; k < n; k++)
                exp_q.push_back('{wen: 1'b1, done: (k == n - 1), busy: (k != n - 1),
                                  addr: 12'((base + k) % 4096), data: 24'(acts[k])});
        end else begin
            nw = (n + 2) / 3;
            for (int w = 0; w < nw; w++) begin
                int word = 0;
                for (int j = 0; j < 3; j++)
                    if (w * 3 + j < n) word += acts[w * 3 + j] * (1 << (8 * j));
                exp_q.push_back('{wen: 1'b1, done: (w == nw - 1), busy: (w != nw - 1),
                                  addr: 12'((base + w) % 4096), data: 24'(word)});
            end
        end
    endtask

    task automatic drive_job(input logic [1:0] layer, input logic [4:0] shift, input logic [11:0] base,
                             input bit extra, input bit poke);
        rec_q.delete();
        @(negedge clk);
        i_start = 1'b1;  i_layer_num = layer;  i_shift = shift;
        i_base_addr = base;  i_num_out = 12'(beat_q.size());
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < beat_q.size(); k++) begin
            i_valid = 1'b1;
            i_data  = beat_q[k];
            if (poke && k == 1) begin
                i_start = 1'b1;  i_layer_num = 2'd0;  i_shift = 5'd7;
                i_base_addr = 12'hABC;  i_num_out = 12'd0;
            end
            @(negedge clk);
            i_start = 1'b0;
            i_valid = 1'b0;
            i_data  = 21'($urandom);
            if (k < beat_q.size() - 1) repeat (gap_q[k]) @(negedge clk);
        end
        for (int t = 0; t < 16 && !o_done; t++) @(negedge clk);
        check("done_seen", {31'd0, o_done}, 32'd1);
        if (extra) begin
            repeat (2) begin
                i_valid = 1'b1;  i_data = 21'($urandom);
                @(negedge clk);
            end
            i_valid = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, rec_q.size(), exp_q.size());
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_wen"},  {31'd0, rec_q[i].wen},  {31'd0, exp_q[i].wen});
            check({tag, "_done"}, {31'd0, rec_q[i].done}, {31'd0, exp_q[i].done});
            check({tag, "_busy"}, {31'd0, rec_q[i].busy}, {31'd0, exp_q[i].busy});
            if (exp_q[i].wen) begin
                check({tag, "_addr"},  {20'd0, rec_q[i].addr}, {20'd0, exp_q[i].addr});
                check({tag, "_wdata"}, {8'd0, rec_q[i].data},  {8'd0, exp_q[i].data});
            end
        end
    endtask

    task automatic load_vec(input vec_t v);
        beat_q.delete();  gap_q.delete();  exp_q.delete();
        for (int k = 0; k < int'(v.num); k++) begin
            beat_q.push_back(v.beats[k]);
            gap_q.push_back((k == int'(v.gap_after)) ? 2 : 0);
        end
        for (int i = 0; i < int'(v.nexp); i++)
            exp_q.push_back('{wen: 1'b1, done: (i == int'(v.nexp) - 1), busy: (i != int'(v.nexp) - 1),
                              addr: v.eaddr[i], data: v.edata[i]});
    endtask

    vec_t tbl[7];

    initial begin
        rst_n = 1'b0;  i_start = 1'b0;  i_layer_num = '0;  i_shift = '0;
        i_base_addr = '0;  i_num_out = '0;  i_valid = 1'b0;  i_data = '0;
        repeat (3) @(negedge clk);
        check("rst_wen",   {31'd0, o_wen},   32'd0);
        check("rst_done",  {31'd0, o_done},  32'd0);
        check("rst_busy",  {31'd0, o_busy},  32'd0);
        check("rst_addr",  {20'd0, o_addr},  32'd0);
        check("rst_wdata", {8'd0, o_wdata},  32'd0);
        rst_n = 1'b1;

        tbl[0] = mk(0, 4,  3, 'h010, 15, 100, 'h1FFFCE, 5000, 0,   1, 'h010, 'hFF0006, 0, 0);
        tbl[1] = mk(1, 0,  4, 'h020, 1,  1, 2, 3, 4,               2, 'h020, 'h030201, 'h021, 'h000004);
        tbl[2] = mk(2, 0,  2, 'h000, 15, 'h1FFFFF, 'h0ABCDE, 0, 0, 2, 'h000, 'hFFFFFF, 'h001, 'h0ABCDE);
        tbl[3] = mk(0, 1,  3, 'h100, 15, 1, 3, 511, 0,             1, 'h100, 'hFF0201, 0, 0);
        tbl[4] = mk(0, 20, 1, 'h200, 15, 'h0FFFFF, 0, 0, 0,        1, 'h200, 'h000001, 0, 0);
        tbl[5] = mk(2, 0,  2, 'hFFF, 15, 5, 'h100000, 0, 0,        2, 'hFFF, 'h000005, 'h000, 'hF00000);
        tbl[6] = mk(0, 0,  2, 'h007, 15, 255, 256, 0, 0,           1, 'h007, 'h00FFFF, 0, 0);

        for (int i = 0; i < 7; i++) begin
            load_vec(tbl[i]);
            drive_job(tbl[i].layer, tbl[i].shift, tbl[i].base, 1'b1, 1'b0);
            compare($sformatf("tbl%0d", i));
        end

        // Zero-length job: done pulse only, never busy
        beat_q.delete();  gap_q.delete();
        model(0, 0, 'h123);
        drive_job(2'd0, 5'd0, 12'h123, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        compare("zero_job");

        // Valid while idle must not produce writes
        rec_q.delete();
        repeat (3) begin
            i_valid = 1'b1;  i_data = 21'($urandom);
            @(negedge clk);
        end
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_valid_writes", rec_q.size(), 0);
        check("idle_valid_busy", {31'd0, o_busy}, 32'd0);

        // Start pulse in the middle of a job must not disturb it
        beat_q = '{21'd9, 21'h1FFFF0};  gap_q = '{0, 0};
        model(2, 0, 'h300);
        drive_job(2'd2, 5'd0, 12'h300, 1'b1, 1'b1);
        compare("start_while_busy");

        // Start presented during DONE is dropped; the following IDLE start is taken
        beat_q = '{21'd7};  gap_q = '{0};
        model(2, 0, 'h400);
        drive_job(2'd2, 5'd0, 12'h400, 1'b0, 1'b0);
        i_start = 1'b1;  i_layer_num = 2'd2;  i_num_out = 12'd1;  i_base_addr = 12'h500;
        @(negedge clk);
        i_start = 1'b0;
        check("b2b_ignored_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(negedge clk);
        compare("b2b_first");
        beat_q = '{21'd8};  gap_q = '{0};
        model(2, 0, 'h500);
        drive_job(2'd2, 5'd0, 12'h500, 1'b1, 1'b0);
        compare("b2b_second");

        // Reset after two of three beats aborts the job
        rec_q.delete();
        @(negedge clk);
        i_start = 1'b1;  i_layer_num = 2'd0;  i_shift = 5'd0;  i_base_addr = 12'h050;  i_num_out = 12'd3;
        @(negedge clk);
        i_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_valid = 1'b1;  i_data = 21'(10 + k);
            @(negedge clk);
        end
        i_valid = 1'b0;
        check("midjob_busy", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",  {31'd0, o_busy},  32'd0);
        check("abort_wen",   {31'd0, o_wen},   32'd0);
        check("abort_done",  {31'd0, o_done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_valid = 1'b1;  i_data = 21'd12;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_write", rec_q.size(), 0);

        load_vec(tbl[0]);
        drive_job(tbl[0].layer, tbl[0].shift, tbl[0].base, 1'b1, 1'b0);
        compare("restart");

        for (int j = 0; j < 40; j++) begin
            int layer, shift, n, base;
            layer = $urandom_range(0, 2);
            shift = $urandom_range(0, 20);
            n     = $urandom_range(1, 8);
            base  = (j % 5 == 0) ? 4094 : $urandom_range(0, 4095);
            beat_q.delete();  gap_q.delete();
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 3))
                    0:       beat_q.push_back(21'($urandom_range(0, 600)));
                    1:       beat_q.push_back(21'($urandom_range(0, 4095) << shift));
                    default: beat_q.push_back(21'($urandom));
                endcase
                gap_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            end
            model(layer, shift, base);
            drive_job(2'(layer), 5'(shift), 12'(base), 1'($urandom_range(0, 1)), 1'b0);
            repeat (2) @(negedge clk);
            compare($sformatf("rnd%0d", j));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cnn_out_writer.md
Name: cnn_out_writer

Overview:
- Consumer at the far end of the convolution/pooling core's 21-bit result stream.
- Applies ReLU, round-and-shift requantization and saturation to produce 8-bit activations.
- Packs CORE_NUM activations into one 24-bit word, the same format the core consumes on its data input, and writes the words to activation SRAM for the next layer.
- For the final layer (layer 2), writes raw sign-extended results one per word instead.

Parameters:
- IN_W, 21, width of core result.
- ACT_W, 8, requantized activation width.
- CORE_NUM, 3, activations per SRAM word.
- ADDR_W, 12, SRAM address width.
- CNT_W, 12, output-count width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; latches the job config. Ignored while o_busy=1.
- i_layer_num  in  2  layer index. Value 2 selects raw mode.
- i_shift  in  5  requant right-shift amount, 0..20.
- i_base_addr  in  ADDR_W  first SRAM write address.
- i_num_out  in  CNT_W  number of results in the job. Must be >=1; a value of 0 completes immediately with no write.
- i_valid  in  1  qualifies i_data. Ignored in IDLE.
- i_data  in  IN_W  signed two's-complement core result.
- o_busy  out  1  high from the cycle after an accepted start until o_done.
- o_wen  out  1  SRAM write strobe, one cycle per word.
- o_addr  out  ADDR_W  write address.
- o_wdata  out  CORE_NUM*ACT_W  write data.
- o_done  out  1  one-cycle pulse, asserted with the last write.

Behaviour:
- Reset: all outputs 0. State=IDLE. Pack register, lane index, count and address registers all 0. Reset mid-job aborts the job; no write or done is produced after rst_n deasserts.
- States:
  - IDLE: i_start latches config, addr<=i_base_addr, cnt<=0, lane<=0, then go to RUN. If i_num_out=0, go to IDLE and pulse o_done the next cycle.
  - RUN: accept beats while i_valid=1.
  - DONE: single cycle, then IDLE.
- Quant mode (layer != 2):
  - r = max(x, 0).
  - If shift=0, q = r; otherwise q = (r + 2^(shift-1)) >> shift.
  - a = min(q, 255). Use an internal sum width of IN_W+1 so the rounding add cannot overflow.
- Packing:
  - Beat k of the word goes into bits [8k+7:8k]; the first beat lands in the LSB byte.
  - Lane increments per beat. When lane reaches CORE_NUM-1, or the beat is the last of the job (cnt=i_num_out-1), the word is complete.
  - Unfilled upper bytes are 0.
  - The lane returns to 0 after each word.
- Raw mode (layer=2): each beat is one word. o_wdata = sign-extend(i_data) to 24 bits. No ReLU, shift or saturation.
- Write timing: the write is a registered output.
  - o_wen=1, with o_addr and o_wdata, appears in the cycle after the accepting edge of the completing beat.
  - addr increments by 1 after each write, wrapping modulo 2^ADDR_W.
- Done: o_done=1 in the same cycle as the final o_wen. State goes to DONE, then IDLE; o_busy drops in the DONE cycle.
- Beats after the last one, and i_valid in IDLE/DONE, are discarded.
- Back-to-back: a new i_start in the DONE cycle is ignored; one is accepted in the IDLE cycle that follows.
- Throughput: one beat per cycle with no stall. The SRAM write port never back-pressures.

Decomposition:
- Shared package holds:
  - IN_W, ACT_W, CORE_NUM.
  - Layer-index constants: LAYER_RAW=2.
  - State encoding (IDLE/RUN/DONE).
- One sub-module: requant_relu. It is combinational, implements ReLU + round-shift + saturate, with inputs i_data and i_shift and output o_act[7:0].
- The FSM, packer and address counter stay in the top module.

Test Plan:
- layer 0, shift 4, num 3, base 0x010; beats 100, -50, 5000 -> single write: addr 0x010, wdata 0xFF0006, o_done in the same cycle.
- layer 1, shift 0, num 4, base 0x020; beats 1, 2, 3, 4 with a 2-cycle i_valid gap between beats 2 and 3 -> writes 0x030201 @0x020 and 0x000004 @0x021; o_done with the second write.
- layer 2, num 2, base 0x000; beats 0x1FFFFF, 0x0ABCDE -> 0xFFFFFF @0x000, 0x0ABCDE @0x001; o_done on the second.
- Rounding edges, shift 1: beats 1, 3, 511 -> bytes 1, 2, 255 -> 0xFF0201. Shift 20: beat 0x0FFFFF -> byte 1.
- Robustness:
  - i_start while busy and i_valid in IDLE -> no config change and no writes.
  - rst_n low after 2 of 3 beats -> all outputs 0 and no write.
  - After restart, a full job completes normally.
- Wrap: base 0xFFF, layer 2, num 2 -> writes @0xFFF, then @0x000.
